// File: rtl/alu_bist_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_bist_pkg / alu_bist_if
// Brief    : ALU opcode encoding and the operand/result bus the BIST drives.
// Revision : 1.0
// ============================================================================

package alu_bist_pkg;

    typedef enum logic [3:0] {
        ALU_ADD      = 4'd0,
        ALU_SUB      = 4'd1,
        ALU_SHIFT_L  = 4'd2,
        ALU_SHIFT_RL = 4'd3,
        ALU_SHIFT_RA = 4'd4,
        ALU_SET_LT   = 4'd5,
        ALU_SET_LTU  = 4'd6,
        ALU_XOR      = 4'd7,
        ALU_OR       = 4'd8,
        ALU_AND      = 4'd9,
        ALU_PASS_A   = 4'd10,
        ALU_PASS_B   = 4'd11,
        ALU_PC_INC   = 4'd12
    } alu_ctrl_e;

    typedef struct packed {
        alu_ctrl_e   op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

endpackage

interface alu_bist_if;
    import alu_bist_pkg::*;

    alu_ctrl_e   alu_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] result;
    logic        zero;

    // master: the BIST sequencer; slave: the ALU under test
    modport master (output alu_op, output in_a, output in_b,
                    input  result, input  zero);
    modport slave  (input  alu_op, input  in_a, input  in_b,
                    output result, output zero);
endinterface

`default_nettype wire

// File: rtl/alu_bist.sv
`default_nettype none
// ============================================================================
// Module   : alu_bist
// Brief    : Self-test sequencer: walks a 16-entry golden vector table through
//            the ALU and reports pass/fail, error count and first failing index.
// Revision : 1.0
// ============================================================================

module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int SETTLE       = 1,
    parameter int STOP_ON_FAIL = 0
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       start_i,
    alu_bist_if.master      alu,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic [4:0]      err_count_o,
    output logic [3:0]      fail_index_o
);

    localparam logic [2:0] C_SETTLE = 3'(SETTLE);
    localparam logic       C_STOP   = (STOP_ON_FAIL != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e      state_q,  state_d;
    logic [3:0]  idx_q,    idx_d;
    logic [2:0]  settle_q, settle_d;
    logic [4:0]  err_q,    err_d;
    logic [3:0]  fail_q,   fail_d;
    logic        pass_q,   pass_d;

    vec_t        w_vec;
    logic        w_mismatch;

    function automatic vec_t vec_lookup(input logic [3:0] i);
        vec_t v;
        case (i)
            4'd0:  v = '{ALU_ADD,      32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF};
            4'd1:  v = '{ALU_ADD,      32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
            4'd2:  v = '{ALU_SUB,      32'h00000000, 32'h00000000, 32'h00000000};
            4'd3:  v = '{ALU_SUB,      32'h00000000, 32'hFFFFFFFF, 32'h00000001};
            4'd4:  v = '{ALU_SHIFT_L,  32'hFDCDEF1F, 32'h00000010, 32'hEF1F0000};
            4'd5:  v = '{ALU_SHIFT_RL, 32'hFDCDEF1F, 32'h00000010, 32'h0000FDCD};
            4'd6:  v = '{ALU_SHIFT_RA, 32'hFDCDEF1F, 32'h40000010, 32'hFFFFFDCD};
            4'd7:  v = '{ALU_SET_LT,   32'hFFFFFFFB, 32'hFFFFFFFF, 32'h00000001};
            4'd8:  v = '{ALU_SET_LT,   32'hFFFFFFFB, 32'hFFFFFFDE, 32'h00000000};
            4'd9:  v = '{ALU_SET_LTU,  32'h00000001, 32'hFFFFFFFB, 32'h00000001};
            4'd10: v = '{ALU_XOR,      32'hFF0000FF, 32'hFFFF0F00, 32'h00FF0FFF};
            4'd11: v = '{ALU_OR,       32'hFF0000FF, 32'hFFFF0F00, 32'hFFFF0FFF};
            4'd12: v = '{ALU_AND,      32'hFF0000FF, 32'hFFFF0F00, 32'hFF000000};
            4'd13: v = '{ALU_PASS_A,   32'hAAAAAAAA, 32'hBBBBBBBB, 32'hAAAAAAAA};
            4'd14: v = '{ALU_PASS_B,   32'hAAAAAAAA, 32'hBBBBBBBB, 32'hBBBBBBBB};
            4'd15: v = '{ALU_PC_INC,   32'h00000000, 32'hBBBBBBBB, 32'h00000004};
        endcase
        return v;
    endfunction

    assign w_vec      = vec_lookup(idx_q);
    assign w_mismatch = (alu.result != w_vec.exp) || (alu.zero != (w_vec.exp == 32'd0));

    // Operands fall back to a benign ADD 0,0 whenever no vector is active
    assign alu.alu_op = (state_q == S_RUN) ? w_vec.op : ALU_ADD;
    assign alu.in_a   = (state_q == S_RUN) ? w_vec.a  : 32'd0;
    assign alu.in_b   = (state_q == S_RUN) ? w_vec.b  : 32'd0;

    assign busy_o       = (state_q == S_RUN);
    assign done_o       = (state_q == S_FINISH);
    assign pass_o       = pass_q;
    assign err_count_o  = err_q;
    assign fail_index_o = fail_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            settle_q <= 3'd0;
            err_q    <= 5'd0;
            fail_q   <= 4'd0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        err_d    = err_q;
        fail_d   = fail_q;
        pass_d   = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    idx_d    = 4'd0;
                    settle_d = 3'd0;
                    err_d    = 5'd0;
                    fail_d   = 4'd0;
                    pass_d   = 1'b0;
                end
            end

            S_RUN: begin
                if (settle_q == C_SETTLE) begin
                    if (w_mismatch) begin
                        if (err_q != 5'd31) begin
                            err_d = err_q + 5'd1;
                        end
                        // err_q only returns to zero on a new start, so zero means first miss
                        if (err_q == 5'd0) begin
                            fail_d = idx_q;
                        end
                    end
                    if ((idx_q == 4'd15) || (w_mismatch && C_STOP)) begin
                        state_d = S_FINISH;
                        pass_d  = (err_d == 5'd0);
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        settle_d = 3'd0;
                    end
                end else begin
                    settle_d = settle_q + 3'd1;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_bist
// Brief    : Scenario table + scoreboard bench for alu_bist across three
//            SETTLE/STOP_ON_FAIL configurations with injectable ALU faults.
// Revision : 1.0
// ============================================================================

module tb_alu_bist;
    import alu_bist_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] start;
    int         fault;          // 0 none, 1 AND returns 0, 2 zero flag stuck at 0

    logic [2:0] busy_w, done_w, pass_w;
    logic [4:0] err_w  [3];
    logic [3:0] fidx_w [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_bist_if u_if0 ();
    alu_bist_if u_if1 ();
    alu_bist_if u_if2 ();

    function automatic logic [31:0] alu_model(input alu_ctrl_e op, input logic [31:0] a,
                                              input logic [31:0] b, input int flt);
        logic [31:0] r;
        case (op)
            ALU_ADD:      r = a + b;
            ALU_SUB:      r = a - b;
            ALU_SHIFT_L:  r = a << b[4:0];
            ALU_SHIFT_RL: r = a >> b[4:0];
            ALU_SHIFT_RA: r = $signed(a) >>> b[4:0];
            ALU_SET_LT:   r = {31'd0, ($signed(a) < $signed(b))};
            ALU_SET_LTU:  r = {31'd0, (a < b)};
            ALU_XOR:      r = a ^ b;
            ALU_OR:       r = a | b;
            ALU_AND:      r = (flt == 1) ? 32'd0 : (a & b);
            ALU_PASS_A:   r = a;
            ALU_PASS_B:   r = b;
            ALU_PC_INC:   r = a + 32'd4;
            default:      r = 32'd0;
        endcase
        return r;
    endfunction

    assign u_if0.result = alu_model(u_if0.alu_op, u_if0.in_a, u_if0.in_b, fault);
    assign u_if1.result = alu_model(u_if1.alu_op, u_if1.in_a, u_if1.in_b, fault);
    assign u_if2.result = alu_model(u_if2.alu_op, u_if2.in_a, u_if2.in_b, fault);
    assign u_if0.zero   = (fault == 2) ? 1'b0 : (u_if0.result == 32'd0);
    assign u_if1.zero   = (fault == 2) ? 1'b0 : (u_if1.result == 32'd0);
    assign u_if2.zero   = (fault == 2) ? 1'b0 : (u_if2.result == 32'd0);

    alu_bist #(.SETTLE(1), .STOP_ON_FAIL(0)) u_dut0 (
        .clk(clk), .reset(reset), .start_i(start[0]), .alu(u_if0.master),
        .busy_o(busy_w[0]), .done_o(done_w[0]), .pass_o(pass_w[0]),
        .err_count_o(err_w[0]), .fail_index_o(fidx_w[0]));

    alu_bist #(.SETTLE(1), .STOP_ON_FAIL(1)) u_dut1 (
        .clk(clk), .reset(reset), .start_i(start[1]), .alu(u_if1.master),
        .busy_o(busy_w[1]), .done_o(done_w[1]), .pass_o(pass_w[1]),
        .err_count_o(err_w[1]), .fail_index_o(fidx_w[1]));

    alu_bist #(.SETTLE(0), .STOP_ON_FAIL(0)) u_dut2 (
        .clk(clk), .reset(reset), .start_i(start[2]), .alu(u_if2.master),
        .busy_o(busy_w[2]), .done_o(done_w[2]), .pass_o(pass_w[2]),
        .err_count_o(err_w[2]), .fail_index_o(fidx_w[2]));

    // Golden stimulus as the table lists it, used to check what dut0 drives
    alu_ctrl_e   t_op [16];
    logic [31:0] t_a  [16];
    logic [31:0] t_b  [16];

    typedef struct {
        int         dut;
        logic       pass;
        logic [4:0] err;
        logic [3:0] fidx;
        int         busy;
    } exp_t;

    typedef struct {
        int         dut;
        int         flt;
        logic       pass;
        logic [4:0] err;
        logic [3:0] fidx;
        int         busy;
    } scen_t;

    exp_t sb [$];
    int   busy_cnt [3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse(input int d);
        @(posedge clk);
        #1 start[d] = 1'b1;
        @(posedge clk);
        #1 start[d] = 1'b0;
    endtask

    task automatic drain(input string nm, input int lim);
        int n;
        n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        chk({"drain_", nm}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    // Monitor: busy-cycle counting, dut0 operand check, scoreboard pop on done
    initial begin
        busy_cnt = '{0, 0, 0};
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (reset) begin
                    busy_cnt[d] = 0;
                end else begin
                    if (d == 0 && busy_w[0]) begin
                        automatic int k = busy_cnt[0] / 2;
                        if (k < 16) begin
                            chk("vec_op", 64'(u_if0.alu_op), 64'(t_op[k]));
                            chk("vec_a",  64'(u_if0.in_a),   64'(t_a[k]));
                            chk("vec_b",  64'(u_if0.in_b),   64'(t_b[k]));
                        end else begin
                            chk("vec_overrun", 64'(k), 64'd15);
                        end
                    end
                    if (busy_w[d]) busy_cnt[d]++;
                    if (done_w[d]) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_done", 64'(done_w[d]), 64'd0);
                        end else begin
                            automatic exp_t e = sb.pop_front();
                            chk("done_dut",   64'(d),           64'(e.dut));
                            chk("done_busy",  64'(busy_w[d]),   64'd0);
                            chk("done_pass",  64'(pass_w[d]),   64'(e.pass));
                            chk("done_err",   64'(err_w[d]),    64'(e.err));
                            chk("done_fidx",  64'(fidx_w[d]),   64'(e.fidx));
                            chk("busy_len",   64'(busy_cnt[d]), 64'(e.busy));
                        end
                        busy_cnt[d] = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t sc [8];

        t_op = '{ALU_ADD, ALU_ADD, ALU_SUB, ALU_SUB, ALU_SHIFT_L, ALU_SHIFT_RL, ALU_SHIFT_RA,
                 ALU_SET_LT, ALU_SET_LT, ALU_SET_LTU, ALU_XOR, ALU_OR, ALU_AND,
                 ALU_PASS_A, ALU_PASS_B, ALU_PC_INC};
        t_a  = '{32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFDCDEF1F,
                 32'hFDCDEF1F, 32'hFDCDEF1F, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h00000001,
                 32'hFF0000FF, 32'hFF0000FF, 32'hFF0000FF, 32'hAAAAAAAA, 32'hAAAAAAAA,
                 32'h00000000};
        t_b  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000010,
                 32'h00000010, 32'h40000010, 32'hFFFFFFFF, 32'hFFFFFFDE, 32'hFFFFFFFB,
                 32'hFFFF0F00, 32'hFFFF0F00, 32'hFFFF0F00, 32'hBBBBBBBB, 32'hBBBBBBBB,
                 32'hBBBBBBBB};

        //          dut flt pass  err    fidx   busy
        sc[0] = '{0, 0, 1'b1, 5'd0, 4'd0,  32};
        sc[1] = '{0, 1, 1'b0, 5'd1, 4'd12, 32};
        sc[2] = '{1, 1, 1'b0, 5'd1, 4'd12, 26};
        sc[3] = '{0, 2, 1'b0, 5'd2, 4'd2,  32};
        sc[4] = '{2, 0, 1'b1, 5'd0, 4'd0,  16};
        sc[5] = '{1, 0, 1'b1, 5'd0, 4'd0,  32};
        sc[6] = '{2, 2, 1'b0, 5'd2, 4'd2,  16};
        sc[7] = '{1, 2, 1'b0, 5'd1, 4'd2,  6};

        reset = 1'b1;
        start = 3'b000;
        fault = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  64'(busy_w[0]),    64'd0);
        chk("rst_done",  64'(done_w[0]),    64'd0);
        chk("rst_pass",  64'(pass_w[0]),    64'd0);
        chk("rst_err",   64'(err_w[0]),     64'd0);
        chk("rst_fidx",  64'(fidx_w[0]),    64'd0);
        chk("rst_op",    64'(u_if0.alu_op), 64'(ALU_ADD));
        chk("rst_a",     64'(u_if0.in_a),   64'd0);
        chk("rst_b",     64'(u_if0.in_b),   64'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            fault = sc[i].flt;
            sb.push_back('{sc[i].dut, sc[i].pass, sc[i].err, sc[i].fidx, sc[i].busy});
            pulse(sc[i].dut);
            drain($sformatf("scen%0d", i), 200);
            repeat (2) @(posedge clk);
            #1;
            chk("pass_hold", 64'(pass_w[sc[i].dut]), 64'(sc[i].pass));
            chk("idle_busy", 64'(busy_w[sc[i].dut]), 64'd0);
        end
        fault = 0;

        // Reset partway through a run: abort without a done pulse
        pulse(0);
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy_w[0]),    64'd0);
        chk("abort_op",   64'(u_if0.alu_op), 64'(ALU_ADD));
        chk("abort_a",    64'(u_if0.in_a),   64'd0);
        chk("abort_b",    64'(u_if0.in_b),   64'd0);
        chk("abort_err",  64'(err_w[0]),     64'd0);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        sb.push_back('{0, 1'b1, 5'd0, 4'd0, 32});
        pulse(0);
        drain("after_abort", 200);

        // Extra start while running is dropped: one 16-cycle run, one done
        sb.push_back('{2, 1'b1, 5'd0, 4'd0, 16});
        pulse(2);
        repeat (4) @(posedge clk);
        pulse(2);
        drain("repulse", 200);
        repeat (30) @(posedge clk);
        #1;
        chk("repulse_idle", 64'(busy_w[2]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Built-in self-test sequencer that drives the ALU operand/opcode interface (alu_op, in_a, in_b) and checks the ALU outputs (result, zero) against a fixed golden vector table.
- Sits beside the combinational alu in the core's execute stage and is muxed onto the ALU inputs while a test runs.
- Gives silicon and FPGA builds a pass/fail check of every AluControl operation without an external testbench.

Parameters:
- SETTLE, 1: wait cycles between applying a vector and sampling the ALU outputs; legal range 0..7.
- STOP_ON_FAIL, 0: 1 = end the run at the first mismatch; 0 = run all vectors and count errors.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a run; honoured only in IDLE
- alu_op  out  AluControl  opcode driven to the ALU
- in_a  out  32  operand A driven to the ALU
- in_b  out  32  operand B driven to the ALU
- result  in  32  ALU result
- zero  in  1  ALU zero flag
- busy  out  1  high while a run is in progress
- done  out  1  one-cycle pulse when a run ends
- pass  out  1  valid from the done pulse until the next start; 1 = no mismatches
- err_count  out  5  number of mismatching vectors in the last run
- fail_index  out  4  index of the first failing vector; 0 if none

Behaviour:
- Reset (synchronous, active-high): state IDLE; alu_op=ALU_ADD, in_a=0, in_b=0; busy=0, done=0, pass=0, err_count=0, fail_index=0. Reset mid-run aborts the run immediately with no done pulse.
- FSM states: IDLE, RUN, FINISH.
  - IDLE: start=1 moves to RUN. On that transition, clear idx, settle_cnt, err_count, fail_index and pass.
  - RUN: drive vector[idx] on alu_op, in_a and in_b. Hold it for SETTLE+1 cycles. Compare in the cycle where settle_cnt==SETTLE.
  - Mismatch: result != exp_result, or zero != (exp_result==0).
  - On a mismatch: increment err_count (saturates at 31). If it is the first mismatch, latch fail_index=idx.
  - After the compare: if idx==15, or a mismatch occurred with STOP_ON_FAIL=1, go to FINISH. Otherwise idx++ and settle_cnt=0.
  - FINISH: for one cycle, done=1, busy=0, pass=(err_count==0); operand outputs return to their idle values. Then go to IDLE.
- busy=1 exactly while in RUN. Full run length = 16*(SETTLE+1) cycles.
- start in RUN or FINISH is ignored, not queued.
- The idx counter is 4 bits; the index never wraps within a run.
- Vector table (op, in_a, in_b -> exp_result):
  - 0: ADD, 00000001, FFFFFFFE -> FFFFFFFF
  - 1: ADD, FFFFFFFF, FFFFFFFF -> FFFFFFFE
  - 2: SUB, 00000000, 00000000 -> 00000000
  - 3: SUB, 00000000, FFFFFFFF -> 00000001
  - 4: SHIFT_L, FDCDEF1F, 00000010 -> EF1F0000
  - 5: SHIFT_RL, FDCDEF1F, 00000010 -> 0000FDCD
  - 6: SHIFT_RA, FDCDEF1F, 40000010 -> FFFFFDCD (shift amount = in_b[4:0] only)
  - 7: SET_LT, FFFFFFFB, FFFFFFFF -> 00000001
  - 8: SET_LT, FFFFFFFB, FFFFFFDE -> 00000000
  - 9: SET_LTU, 00000001, FFFFFFFB -> 00000001
  - 10: XOR, FF0000FF, FFFF0F00 -> 00FF0FFF
  - 11: OR, FF0000FF, FFFF0F00 -> FFFF0FFF
  - 12: AND, FF0000FF, FFFF0F00 -> FF000000
  - 13: PASS_A, AAAAAAAA, BBBBBBBB -> AAAAAAAA
  - 14: PASS_B, AAAAAAAA, BBBBBBBB -> BBBBBBBB
  - 15: PC_INC, 00000000, BBBBBBBB -> 00000004

Test Plan:
- Correct alu connected, SETTLE=1, one-cycle start pulse -> busy high for 32 cycles, then done pulse with pass=1, err_count=0, fail_index=0.
- ALU model forced to AND result 0, STOP_ON_FAIL=0 -> done after 32 busy cycles; pass=0, err_count=1, fail_index=12.
- Same fault, STOP_ON_FAIL=1 -> done after 13*(SETTLE+1)=26 busy cycles; err_count=1, fail_index=12.
- Zero flag stuck at 0 -> vectors 2 and 8 fail; err_count=2, fail_index=2.
- reset asserted at cycle 10 of a run -> next cycle state IDLE, busy=0, alu_op=ALU_ADD, in_a=in_b=0, no done pulse. A fresh start then gives pass=1.
- start re-pulsed during RUN, and SETTLE=0 -> the extra start is ignored; busy lasts 16 cycles and a single done pulse is issued.
